// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
// Wide unsigned adder that time-shares one 4-bit ripple-carry adder.
// Each nibble uses two adder passes: operand add, then carry-in add.
// {cout, sum} = a + b appears after exactly 2*NIBBLES edges of work,
// followed by a one-cycle done pulse.

module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADD_AB = 2'd1,
        ST_ADD_CI = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_r_q, a_r_d;
    logic [W-1:0]    b_r_q, b_r_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [3:0]      tmp_q, tmp_d;
    logic            c1_q, c1_d;
    logic [W-1:0]    sum_r_q, sum_r_d;
    logic            cout_r_q, cout_r_d;

    // Shared nibble adder operands and results.
    logic [3:0] adder_a;
    logic [3:0] adder_b;
    logic [3:0] adder_s;
    logic       adder_co;

    // Bit offset of the current nibble inside the wide operands.
    logic [IDXW+1:0] nib_base;
    assign nib_base = {idx_q, 2'b00};

    RippleCarryAdder u_adder (
        .A  (adder_a),
        .B  (adder_b),
        .S  (adder_s),
        .Co (adder_co)
    );

    // State and datapath registers; synchronous active-low reset clears everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_r_q    <= '0;
            b_r_q    <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            tmp_q    <= '0;
            c1_q     <= 1'b0;
            sum_r_q  <= '0;
            cout_r_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_r_q    <= a_r_d;
            b_r_q    <= b_r_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            tmp_q    <= tmp_d;
            c1_q     <= c1_d;
            sum_r_q  <= sum_r_d;
            cout_r_q <= cout_r_d;
        end
    end

    // Next-state, adder operand steering and register updates per state.
    always_comb begin
        state_d  = state_q;
        a_r_d    = a_r_q;
        b_r_d    = b_r_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        tmp_d    = tmp_q;
        c1_d     = c1_q;
        sum_r_d  = sum_r_q;
        cout_r_d = cout_r_q;
        adder_a  = '0;
        adder_b  = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_r_d    = a;
                    b_r_d    = b;
                    idx_d    = '0;
                    carry_d  = 1'b0;
                    sum_r_d  = '0;
                    cout_r_d = 1'b0;
                    state_d  = ST_ADD_AB;
                end
            end

            ST_ADD_AB: begin
                adder_a = a_r_q[nib_base +: 4];
                adder_b = b_r_q[nib_base +: 4];
                tmp_d   = adder_s;
                c1_d    = adder_co;
                state_d = ST_ADD_CI;
            end

            ST_ADD_CI: begin
                // First-pass and second-pass carries are mutually exclusive,
                // so their OR is the exact carry out of this nibble.
                adder_a = tmp_q;
                adder_b = {3'b000, carry_q};
                sum_r_d[nib_base +: 4] = adder_s;
                carry_d = c1_q | adder_co;
                if (idx_q == LAST_IDX) begin
                    cout_r_d = c1_q | adder_co;
                    state_d  = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_ADD_AB;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake flags decode directly from the registered state.
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_r_q;
    assign cout = cout_r_q;

endmodule

// RippleCarryAdder
// 4-bit ripple-carry adder without carry-in; shared nibble datapath.

module RippleCarryAdder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] S,
    output logic       Co
);

    logic [4:0] c;

    // Full-adder chain, LSB to MSB.
    always_comb begin
        c    = '0;
        S    = '0;
        c[0] = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            S[i]   = A[i] ^ B[i] ^ c[i];
            c[i+1] = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i]);
        end
    end

    assign Co = c[4];

endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencer that performs a wide unsigned addition by time-sharing one 4-bit `RippleCarryAdder` instance (ports A, B, S, Co; no carry-in).
- Each nibble takes two adder passes: operand add, then carry-in add.
- A 4·NIBBLES-bit result and carry-out are produced after a fixed latency.
- Sits between a start/done requester and the shared nibble adder; the adder is instantiated inside this block.

## Interface
- NIBBLES, 4, number of 4-bit slices; W = 4*NIBBLES, must be ≥ 1.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- start  input  1  request; sampled only in IDLE.
- a  input  W  operand A; captured on the accepting edge.
- b  input  W  operand B; captured on the accepting edge.
- busy  output  1  high from the accepting edge until the return to IDLE.
- done  output  1  one-cycle pulse; sum and cout are valid while it is high.
- sum  output  W  result; held until the next accepted start.
- cout  output  1  carry out of the MSB nibble; held with sum.

## Operation
- State machine: IDLE, ADD_AB, ADD_CI, DONE.
- Internal registers:
  - a_r, b_r: captured operands.
  - idx: nibble index, clog2(NIBBLES) bits, minimum 1 bit.
  - carry: running carry.
  - tmp: 4-bit partial sum.
  - c1: carry from the first pass.
  - sum_r, cout_r.
- IDLE:
  - busy=0.
  - On start=1: a_r←a, b_r←b, idx←0, carry←0, sum_r←0, cout_r←0; go to ADD_AB.
- ADD_AB:
  - Adder A=a_r[4*idx+:4], B=b_r[4*idx+:4].
  - tmp←S, c1←Co; go to ADD_CI.
- ADD_CI:
  - Adder A=tmp, B={3'b000,carry}.
  - sum_r[4*idx+:4]←S, carry←c1|Co.
  - If idx==NIBBLES-1: cout_r←c1|Co, go to DONE.
  - Otherwise: idx←idx+1, go to ADD_AB.
- DONE: done=1, busy=1; go to IDLE unconditionally.
- Arithmetic: c1 and the second-pass Co are never both 1 (a+b ≤ 30 gives tmp ≤ 14), so c1|Co is the exact nibble carry.
- {cout,sum} = a+b, computed modulo 2^(W+1).
- Adder inputs in IDLE/DONE are driven to 0; their value is don't-care.
- start while busy (ADD_AB, ADD_CI, DONE) is ignored; it is not queued.
- Operand inputs changing after the accepting edge have no effect.
- Reset mid-operation:
  - State→IDLE.
  - All registers cleared; the in-flight result is discarded.
  - No done pulse is issued.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, state=IDLE, idx=0, carry=0.
- Accepting edge = rising edge with state IDLE, rst_n=1, start=1. busy is high in the cycle after it.
- Work takes exactly 2*NIBBLES edges. done is high in the cycle following the 2*NIBBLES-th edge after the accepting edge (8th for NIBBLES=4).
- done width is exactly one cycle. busy falls on the following edge.
- Earliest next accept is the edge after done drops: one accept every 2*NIBBLES+2 cycles.
- Latency is data-independent; the carry pass always executes, even when carry=0.
- rst_n low has priority over start on the same edge.
- sum/cout are registered outputs with no combinational path from a, b or start.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with start=1 → busy=0, done=0, sum=0x0000, cout=0; release and confirm IDLE with start=0.
- Basic (NIBBLES=4): a=0x1234, b=0x1111, start pulse → busy next cycle; done on the 8th edge after accept; sum=0x2345, cout=0; done lasts 1 cycle; sum still 0x2345 three cycles later.
- Carry ripple through second passes: a=0x0FFF, b=0x0001 → sum=0x1000, cout=0. Then a=0xFFFF, b=0xFFFF → sum=0xFFFE, cout=1.
- Busy-ignore:
  - Accept a=0x8000, b=0x8000.
  - Assert start with a=0x1111, b=0x1111 on edges 3 and 8 after accept.
  - Expect one done with sum=0x0000, cout=1, and no second operation.
- Reset mid-op: accept 0xAAAA+0x5555, drop rst_n at edge 4 for one cycle → no done, sum=0; then accept 0x00FF+0x0001 → sum=0x0100, cout=0 at the 8th edge.
- Back-to-back: hold start=1 continuously with fixed a=0x0007, b=0x0008 → done pulses exactly 10 cycles apart; each result sum=0x000F, cout=0.
